collision_scheduler: RTL and testbench
======================================

Name: collision_scheduler

Overview:
- Time-multiplexes one registered rectangle-overlap checker across N_OBJ moving objects × N_PAD paddles, once per frame.
- Started by a frame-start pulse from the VGA timing logic during vertical blanking.
- Publishes a latched per-pair hit mask plus a one-cycle done pulse to the game-state/bounce logic.
- Replaces per-object parallel comparator trees with one shared datapath.

Parameters:
- N_OBJ, 4, number of objects (balls/blocks) checked each frame
- N_PAD, 2, number of paddles
- COORD_W, 10, coordinate/size width in pixels

Ports:
- pixel_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle pulse; requests one full scan
- obj_valid  in  N_OBJ  object i is live; dead objects never report hits
- obj_x, obj_y  in  N_OBJ*COORD_W  packed top-left corners, object i at bits [i*COORD_W +: COORD_W]
- obj_w, obj_h  in  N_OBJ*COORD_W  packed object sizes
- pad_x, pad_y, pad_w, pad_h  in  N_PAD*COORD_W  packed paddle rectangles, same packing
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; hit_mask updated on the same edge
- hit_mask  out  N_OBJ*N_PAD  bit (i*N_PAD+j) set when object i overlaps paddle j
- overrun  out  1  present only with the optional feature

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, counters 0, busy=0, done=0, hit_mask=0, overrun=0.
- FSM states and transitions:
  - IDLE: on frame_start=1, go to SNAP.
  - SNAP: register all object/paddle inputs and obj_valid into a snapshot. The scan uses only the snapshot; input changes mid-scan have no effect. Go to CHECK with obj_idx=0, pad_idx=0.
  - CHECK: each cycle, present pair (obj_idx, pad_idx) to the checker.
    - pad_idx increments first; on wrap to 0, obj_idx increments.
    - After pair (N_OBJ-1, N_PAD-1), go to DRAIN.
  - DRAIN: one cycle to capture the final checker result, then go to DONE.
  - DONE: copy the scratch mask to hit_mask, pulse done=1 for exactly this cycle, return to IDLE.
- busy=1 in SNAP, CHECK, DRAIN and DONE; 0 only in IDLE.
- Latency:
  - P = N_OBJ*N_PAD.
  - done asserts exactly P+3 cycles after the cycle in which frame_start is sampled high in IDLE (default: 11).
  - Fixed, independent of obj_valid.
- Checker arithmetic:
  - Sums are extended to COORD_W+1 bits, so there is no wrap-around.
  - hit = (ox <= px+pw) && (ox+ow >= px) && (oy <= py+ph) && (oy+oh >= py).
  - Edges are inclusive: touching counts as a hit.
  - Result is registered with 1-cycle latency, then ANDed with the snapshot obj_valid[i].
- The scratch mask clears in SNAP. hit_mask holds its previous value until DONE.
- frame_start while busy=1 is ignored; no queuing.
- frame_start in the same cycle as DONE is ignored. The next scan needs a new pulse in IDLE.
- Zero-size rectangle (w=0 or h=0) is treated as a point/line; inclusive compare still applies.
- Reset mid-scan aborts immediately. hit_mask is cleared, not partially updated.

Optional Feature:
- Macro: COLLISION_OVERRUN_EN.
- Defined:
  - overrun port exists.
  - Sticky set when frame_start=1 while busy=1.
  - Cleared only by reset_n.
- Undefined:
  - No overrun port and no logic; frame_start while busy is silently dropped.

Decomposition:
- Package collision_pkg:
  - COORD_W default.
  - FSM state encoding: IDLE, SNAP, CHECK, DRAIN, DONE.
  - Constant function for pair count P and counter widths ($clog2 of N_OBJ and N_PAD, minimum 1).
- Sub-module rect_overlap_check:
  - Registered single-pair comparator, one-cycle latency.
  - Ports: pixel_clk, reset_n, valid_in, eight coordinate/size inputs, valid_out, hit.
  - Scheduler tracks the result index with a delayed copy of (obj_idx, pad_idx).

Test Plan:
- Reset/latency:
  - Stimulus: release reset, pulse frame_start.
  - Required: busy rises the next cycle, done pulses exactly 11 cycles after the pulse, hit_mask=0 with all objects far from the paddles.
- Single hit:
  - Stimulus: obj0 at (20,100) size 16×16; pad1 at (30,90) size 8×64.
  - Required: hit_mask = 8'b0000_0010 only.
- Edge touch vs gap:
  - Stimulus: obj2 at x=22, w=8, pad0 at x=30 (touch, ox+ow=30); then repeat with pad0 at x=31 (gap).
  - Required: bit 4 set for the touch; bit 4 clear for the gap.
- Invalid and overflow:
  - Stimulus: obj3 overlapping pad0 with obj_valid[3]=0.
    - Required: bit 6 clear.
  - Stimulus: obj1 at x=1020, w=10, pad1 at x=1023.
    - Required: bit 3 set; no wrap false-negative.
- Snapshot/ignore:
  - Stimulus: move obj0 off the paddle and pulse frame_start in cycle 5 of a scan.
  - Required: result reflects the snapshot; no second done; overrun=1 when COLLISION_OVERRUN_EN is defined.
- Reset mid-scan:
  - Stimulus: assert reset_n=0 in cycle 6.
  - Required: busy, done and hit_mask go to 0 asynchronously; a later frame_start runs a full, correct scan.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and sizing helpers for the frame collision scheduler.
package collision_pkg;

    localparam int COORD_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_CHECK,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int pair_cnt(input int n_obj, input int n_pad);
        return n_obj * n_pad;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collision_scheduler_rect_overlap_check.sv
// Registered single-pair rectangle overlap comparator, one-cycle latency.
// Edges are inclusive; sums carry one extra bit so they never wrap.
module rect_overlap_check
    import collision_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               pixel_clk,
    input  logic               reset_n,
    input  logic               valid_in,
    input  logic [COORD_W-1:0] ox,
    input  logic [COORD_W-1:0] oy,
    input  logic [COORD_W-1:0] ow,
    input  logic [COORD_W-1:0] oh,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] pw,
    input  logic [COORD_W-1:0] ph,
    output logic               valid_out,
    output logic               hit
);

    logic [COORD_W:0] o_r, o_b, p_r, p_b;
    logic [COORD_W:0] o_l, o_t, p_l, p_t;
    logic             hit_d;
    logic             valid_q, hit_q;

    assign o_l = {1'b0, ox};
    assign o_t = {1'b0, oy};
    assign p_l = {1'b0, px};
    assign p_t = {1'b0, py};
    assign o_r = o_l + {1'b0, ow};
    assign o_b = o_t + {1'b0, oh};
    assign p_r = p_l + {1'b0, pw};
    assign p_b = p_t + {1'b0, ph};

    assign hit_d = (o_l <= p_r) && (o_r >= p_l) &&
                   (o_t <= p_b) && (o_b >= p_t);

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            valid_q <= valid_in;
            hit_q   <= valid_in & hit_d;
        end
    end

    assign valid_out = valid_q;
    assign hit       = hit_q;

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame object x paddle collision scan through one shared comparator.
// Define COLLISION_OVERRUN_EN to add the sticky overrun flag.
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int N_OBJ   = 4,
    parameter int N_PAD   = 2,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic                     pixel_clk,
    input  logic                     reset_n,
    input  logic                     frame_start,
    input  logic [N_OBJ-1:0]         obj_valid,
    input  logic [N_OBJ*COORD_W-1:0] obj_x,
    input  logic [N_OBJ*COORD_W-1:0] obj_y,
    input  logic [N_OBJ*COORD_W-1:0] obj_w,
    input  logic [N_OBJ*COORD_W-1:0] obj_h,
    input  logic [N_PAD*COORD_W-1:0] pad_x,
    input  logic [N_PAD*COORD_W-1:0] pad_y,
    input  logic [N_PAD*COORD_W-1:0] pad_w,
    input  logic [N_PAD*COORD_W-1:0] pad_h,
    output logic                     busy,
    output logic                     done,
    output logic [N_OBJ*N_PAD-1:0]   hit_mask
`ifdef COLLISION_OVERRUN_EN
    ,
    output logic                     overrun
`endif
);

    localparam int P  = pair_cnt(N_OBJ, N_PAD);
    localparam int OW = idx_w(N_OBJ);
    localparam int PW = idx_w(N_PAD);
    localparam logic [OW-1:0] OBJ_LAST = OW'(N_OBJ - 1);
    localparam logic [PW-1:0] PAD_LAST = PW'(N_PAD - 1);

    state_e                   state_q;
    logic [OW-1:0]            obj_idx_q, res_obj_q;
    logic [PW-1:0]            pad_idx_q, res_pad_q;
    logic                     busy_q, done_q;
    logic [P-1:0]             hit_mask_q, scratch_q, mask_upd;

    logic [N_OBJ-1:0]         obj_valid_q;
    logic [N_OBJ*COORD_W-1:0] obj_x_q, obj_y_q, obj_w_q, obj_h_q;
    logic [N_PAD*COORD_W-1:0] pad_x_q, pad_y_q, pad_w_q, pad_h_q;

    logic                     chk_vin, chk_vout, chk_hit;
    logic [COORD_W-1:0]       s_ox, s_oy, s_ow, s_oh;
    logic [COORD_W-1:0]       s_px, s_py, s_pw, s_ph;

    // The scan reads only this snapshot, so inputs may move mid-scan.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            obj_valid_q <= '0;
            obj_x_q     <= '0;
            obj_y_q     <= '0;
            obj_w_q     <= '0;
            obj_h_q     <= '0;
            pad_x_q     <= '0;
            pad_y_q     <= '0;
            pad_w_q     <= '0;
            pad_h_q     <= '0;
        end else if (state_q == ST_SNAP) begin
            obj_valid_q <= obj_valid;
            obj_x_q     <= obj_x;
            obj_y_q     <= obj_y;
            obj_w_q     <= obj_w;
            obj_h_q     <= obj_h;
            pad_x_q     <= pad_x;
            pad_y_q     <= pad_y;
            pad_w_q     <= pad_w;
            pad_h_q     <= pad_h;
        end
    end

    assign chk_vin = (state_q == ST_CHECK);
    assign s_ox = obj_x_q[int'(obj_idx_q)*COORD_W +: COORD_W];
    assign s_oy = obj_y_q[int'(obj_idx_q)*COORD_W +: COORD_W];
    assign s_ow = obj_w_q[int'(obj_idx_q)*COORD_W +: COORD_W];
    assign s_oh = obj_h_q[int'(obj_idx_q)*COORD_W +: COORD_W];
    assign s_px = pad_x_q[int'(pad_idx_q)*COORD_W +: COORD_W];
    assign s_py = pad_y_q[int'(pad_idx_q)*COORD_W +: COORD_W];
    assign s_pw = pad_w_q[int'(pad_idx_q)*COORD_W +: COORD_W];
    assign s_ph = pad_h_q[int'(pad_idx_q)*COORD_W +: COORD_W];

    rect_overlap_check #(
        .COORD_W (COORD_W)
    ) u_chk (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .valid_in  (chk_vin),
        .ox        (s_ox),
        .oy        (s_oy),
        .ow        (s_ow),
        .oh        (s_oh),
        .px        (s_px),
        .py        (s_py),
        .pw        (s_pw),
        .ph        (s_ph),
        .valid_out (chk_vout),
        .hit       (chk_hit)
    );

    // Index of the pair whose result the checker is presenting now.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            res_obj_q <= '0;
            res_pad_q <= '0;
        end else if (chk_vin) begin
            res_obj_q <= obj_idx_q;
            res_pad_q <= pad_idx_q;
        end
    end

    always_comb begin
        mask_upd = scratch_q;
        if (chk_vout) begin
            mask_upd[int'(res_obj_q)*N_PAD + int'(res_pad_q)] =
                chk_hit & obj_valid_q[res_obj_q];
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            obj_idx_q  <= '0;
            pad_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_mask_q <= '0;
            scratch_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            scratch_q <= mask_upd;
            unique case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q <= ST_SNAP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SNAP: begin
                    scratch_q <= '0;
                    obj_idx_q <= '0;
                    pad_idx_q <= '0;
                    state_q   <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (pad_idx_q == PAD_LAST) begin
                        pad_idx_q <= '0;
                        if (obj_idx_q == OBJ_LAST) begin
                            obj_idx_q <= '0;
                            state_q   <= ST_DRAIN;
                        end else begin
                            obj_idx_q <= obj_idx_q + OW'(1);
                        end
                    end else begin
                        pad_idx_q <= pad_idx_q + PW'(1);
                    end
                end
                // Final result lands here; publish it with the done pulse.
                ST_DRAIN: begin
                    hit_mask_q <= mask_upd;
                    done_q     <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hit_mask = hit_mask_q;

`ifdef COLLISION_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (frame_start && busy_q) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: directed cases plus random frames.
module tb_collision_scheduler;

    logic        pixel_clk;
    logic        reset_n;
    logic        frame_start;
    logic [3:0]  obj_valid;
    logic [39:0] obj_x, obj_y, obj_w, obj_h;
    logic [19:0] pad_x, pad_y, pad_w, pad_h;
    logic        busy, done;
    logic [7:0]  hit_mask;
`ifdef COLLISION_OVERRUN_EN
    logic        overrun;
`endif

    int mox[4], moy[4], mow[4], moh[4];
    int mpx[2], mpy[2], mpw[2], mph[2];
    logic [3:0] mv;

    int n_assert = 0;
    int n_fail   = 0;

    collision_scheduler dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .obj_valid   (obj_valid),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_w       (obj_w),
        .obj_h       (obj_h),
        .pad_x       (pad_x),
        .pad_y       (pad_y),
        .pad_w       (pad_w),
        .pad_h       (pad_h),
        .busy        (busy),
        .done        (done),
        .hit_mask    (hit_mask)
`ifdef COLLISION_OVERRUN_EN
        ,
        .overrun     (overrun)
`endif
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        obj_valid = mv;
        for (int i = 0; i < 4; i++) begin
            obj_x[i*10 +: 10] = 10'(mox[i]);
            obj_y[i*10 +: 10] = 10'(moy[i]);
            obj_w[i*10 +: 10] = 10'(mow[i]);
            obj_h[i*10 +: 10] = 10'(moh[i]);
        end
        for (int j = 0; j < 2; j++) begin
            pad_x[j*10 +: 10] = 10'(mpx[j]);
            pad_y[j*10 +: 10] = 10'(mpy[j]);
            pad_w[j*10 +: 10] = 10'(mpw[j]);
            pad_h[j*10 +: 10] = 10'(mph[j]);
        end
    endtask

    task automatic set_far();
        for (int i = 0; i < 4; i++) begin
            mox[i] = 40 + 60 * i;
            moy[i] = 10;
            mow[i] = 8;
            moh[i] = 8;
        end
        for (int j = 0; j < 2; j++) begin
            mpx[j] = 500 + 200 * j;
            mpy[j] = 400;
            mpw[j] = 8;
            mph[j] = 64;
        end
        mv = 4'hF;
        apply();
    endtask

    task automatic set_single_hit();
        set_far();
        mox[0] = 20; moy[0] = 100; mow[0] = 16; moh[0] = 16;
        mpx[1] = 30; mpy[1] = 90;  mpw[1] = 8;  mph[1] = 64;
        apply();
    endtask

    // Reference: plain integer rectangle test on live objects.
    function automatic logic [7:0] model();
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++)
                if (mv[i] &&
                    mox[i] <= mpx[j] + mpw[j] && mox[i] + mow[i] >= mpx[j] &&
                    moy[i] <= mpy[j] + mph[j] && moy[i] + moh[i] >= mpy[j])
                    m[i*2+j] = 1'b1;
        return m;
    endfunction

    // action: 0 plain, 1 move obj0 and re-pulse at cycle 5, 2 reset at cycle 6
    task automatic do_frame(input logic [7:0] exp, input string tag,
                            input int action);
        int k;
        int extra;
        chk({"idle_busy_", tag}, 32'(busy), 32'd0);
        frame_start = 1'b1;
        @(negedge pixel_clk);
        frame_start = 1'b0;
        chk({"busy_rise_", tag}, 32'(busy), 32'd1);
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            frame_start = (action == 1 && k == 5);
            if (action == 1 && k == 5) begin
                mox[0] = 700;
                apply();
            end
            if (action == 2 && k == 6) begin
                frame_start = 1'b0;
                reset_n = 1'b0;
                #1;
                chk({"rst_busy_", tag}, 32'(busy), 32'd0);
                chk({"rst_done_", tag}, 32'(done), 32'd0);
                chk({"rst_mask_", tag}, 32'(hit_mask), 32'd0);
                return;
            end
            @(negedge pixel_clk);
            k++;
        end
        frame_start = 1'b0;
        chk({"latency_", tag}, 32'(k), 32'd11);
        chk({"mask_", tag}, 32'(hit_mask), 32'(exp));
        @(negedge pixel_clk);
        chk({"done_pulse_", tag}, 32'(done), 32'd0);
        chk({"busy_fall_", tag}, 32'(busy), 32'd0);
        chk({"mask_hold_", tag}, 32'(hit_mask), 32'(exp));
        if (action == 1) begin
            extra = 0;
            repeat (15) begin
                @(negedge pixel_clk);
                if (done === 1'b1) extra++;
            end
            chk({"no_second_done_", tag}, 32'(extra), 32'd0);
`ifdef COLLISION_OVERRUN_EN
            chk({"overrun_set_", tag}, 32'(overrun), 32'd1);
`endif
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_start = 1'b0;
        set_far();
        repeat (3) @(negedge pixel_clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mask", 32'(hit_mask), 32'd0);
`ifdef COLLISION_OVERRUN_EN
        chk("reset_overrun", 32'(overrun), 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge pixel_clk);

        do_frame(8'h00, "far", 0);

        set_single_hit();
        do_frame(8'h02, "single", 0);

        set_far();
        mox[2] = 22; moy[2] = 200; mow[2] = 8; moh[2] = 8;
        mpx[0] = 30; mpy[0] = 190; mpw[0] = 8; mph[0] = 40;
        apply();
        do_frame(8'h10, "touch", 0);
        mpx[0] = 31;
        apply();
        do_frame(8'h00, "gap", 0);

        set_far();
        mox[3] = 32; moy[3] = 200; mow[3] = 4; moh[3] = 4;
        mpx[0] = 30; mpy[0] = 190; mpw[0] = 8; mph[0] = 40;
        mv = 4'h7;
        apply();
        do_frame(8'h00, "invalid", 0);
        mv = 4'hF;
        apply();
        do_frame(8'h40, "valid3", 0);

        set_far();
        mox[1] = 1020; moy[1] = 300; mow[1] = 10; moh[1] = 10;
        mpx[1] = 1023; mpy[1] = 295; mpw[1] = 0;  mph[1] = 20;
        apply();
        do_frame(8'h08, "overflow", 0);

        set_single_hit();
        do_frame(8'h02, "snapshot", 1);

        set_single_hit();
        do_frame(8'h02, "pre_rst", 0);
        do_frame(8'h00, "midrst", 2);
        @(negedge pixel_clk);
        reset_n = 1'b1;
        @(negedge pixel_clk);
`ifdef COLLISION_OVERRUN_EN
        chk("overrun_cleared", 32'(overrun), 32'd0);
`endif
        set_single_hit();
        do_frame(8'h02, "post_rst", 0);

        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < 4; i++) begin
                if (f % 3 == 2) mox[i] = int'($urandom_range(900, 1023));
                else            mox[i] = int'($urandom_range(0, 120));
                moy[i] = int'($urandom_range(0, 120));
                mow[i] = int'($urandom_range(0, 40));
                moh[i] = int'($urandom_range(0, 40));
            end
            for (int j = 0; j < 2; j++) begin
                if (f % 3 == 2) mpx[j] = int'($urandom_range(900, 1023));
                else            mpx[j] = int'($urandom_range(0, 120));
                mpy[j] = int'($urandom_range(0, 120));
                mpw[j] = int'($urandom_range(0, 40));
                mph[j] = int'($urandom_range(0, 40));
            end
            mv = 4'($urandom);
            apply();
            do_frame(model(), $sformatf("rand%0d", f), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
